// File: rtl/vga_480p_timing.sv
// rtl/vga_480p_timing.sv - VGA 640x480@60 timing generator driven by a pixel strobe in the clk_50m domain
// Optional 4-bit test pattern outputs are enabled by defining VGA_480P_TEST_PATTERN_EN.
module vga_480p_timing #(
  parameter int CORDW    = 10,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic             clk_50m,
  input  logic             rst,
  output logic             pix_stb,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
`ifdef VGA_480P_TEST_PATTERN_EN
  ,
  output logic [3:0]       pat_r,
  output logic [3:0]       pat_g,
  output logic [3:0]       pat_b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ACT = (SYNC_POL != 0);

  logic [DIVW-1:0]  div_q, div_d;
  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             stb;
  logic             hs_act;
  logic             vs_act;

  assign stb = (div_q == DIV_LAST);

  always_comb begin
    div_d = stb ? '0 : div_q + DIVW'(1);
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (stb) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
      end else begin
        sx_d = sx_q + CORDW'(1);
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      div_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      div_q <= div_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // Every decode is forced idle while rst is high, even though sx/sy already read (0,0).
  assign hs_act  = (sx_q >= HS_START) && (sx_q <= HS_END);
  assign vs_act  = (sy_q >= VS_START) && (sy_q <= VS_END);
  assign pix_stb = stb && !rst;
  assign sx      = sx_q;
  assign sy      = sy_q;
  assign hsync   = (hs_act && !rst) ? SYNC_ACT : ~SYNC_ACT;
  assign vsync   = (vs_act && !rst) ? SYNC_ACT : ~SYNC_ACT;
  assign de      = !rst && (sx_q < H_ACT) && (sy_q < V_ACT);
  assign line    = !rst && (sx_q == '0);
  assign frame   = !rst && (sx_q == '0) && (sy_q == '0);

`ifdef VGA_480P_TEST_PATTERN_EN
  localparam logic [CORDW-1:0] SQ_X0 = CORDW'(220);
  localparam logic [CORDW-1:0] SQ_X1 = CORDW'(420);
  localparam logic [CORDW-1:0] SQ_Y0 = CORDW'(140);
  localparam logic [CORDW-1:0] SQ_Y1 = CORDW'(340);

  logic in_sq;
  assign in_sq = (sx_q > SQ_X0) && (sx_q < SQ_X1) && (sy_q > SQ_Y0) && (sy_q < SQ_Y1);

  always_comb begin
    pat_r = 4'h0;
    pat_g = 4'h0;
    pat_b = 4'h0;
    if (de) begin
      pat_r = in_sq ? 4'hF : 4'h1;
      pat_g = in_sq ? 4'hF : 4'h3;
      pat_b = in_sq ? 4'hF : 4'h7;
    end
  end
`endif

endmodule

// File: tb/tb_vga_480p_timing.sv
// tb/tb_vga_480p_timing.sv - checks vga_480p_timing at default timing (u_a) and a shrunk CLK_DIV=4 timing (u_b)
module tb_vga_480p_timing;

  typedef struct {
    int pix, sx, sy, hs, vs, de, line, frame, pr, pg, pb;
  } exp_t;

  typedef struct {
    int k, sx, sy, pix, de, hs, line, frame;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic pix_a, hs_a, vs_a, de_a, line_a, frame_a;
  logic pix_b, hs_b, vs_b, de_b, line_b, frame_b;
  logic [9:0] sx_a, sy_a, sx_b, sy_b;
`ifdef VGA_480P_TEST_PATTERN_EN
  logic [3:0] pr_a, pg_a, pb_a, pr_b, pg_b, pb_b;
`endif

  int checks = 0;
  int errors = 0;
  int k_a = 0;
  int k_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb, aa, ab;
  vec_t tbl[12];

  always #10 clk = ~clk;

  vga_480p_timing u_a (
    .clk_50m(clk), .rst(rst_a), .pix_stb(pix_a), .sx(sx_a), .sy(sy_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .line(line_a), .frame(frame_a)
`ifdef VGA_480P_TEST_PATTERN_EN
    , .pat_r(pr_a), .pat_g(pg_a), .pat_b(pb_a)
`endif
  );

  vga_480p_timing #(
    .CORDW(10), .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)
  ) u_b (
    .clk_50m(clk), .rst(rst_b), .pix_stb(pix_b), .sx(sx_b), .sy(sy_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .line(line_b), .frame(frame_b)
`ifdef VGA_480P_TEST_PATTERN_EN
    , .pat_r(pr_b), .pat_g(pg_b), .pat_b(pb_b)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position derived from k = clocks since the reset edge, not from a counter chain.
  function automatic exp_t model(input int k, input bit r, input int cdiv,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input int pol);
    exp_t m;
    int ht, vt, p, x, y;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p = k / cdiv;
    x = p % ht;
    y = (p / ht) % vt;
    m.sx = x;
    m.sy = y;
    m.pix = (!r && (k % cdiv == cdiv - 1)) ? 1 : 0;
    m.de = (!r && x < ha && y < va) ? 1 : 0;
    m.hs = (!r && x >= ha + hfp && x < ha + hfp + hsw) ? pol : 1 - pol;
    m.vs = (!r && y >= va + vfp && y < va + vfp + vsw) ? pol : 1 - pol;
    m.line = (!r && x == 0) ? 1 : 0;
    m.frame = (!r && x == 0 && y == 0) ? 1 : 0;
    if (m.de == 0) begin
      m.pr = 0; m.pg = 0; m.pb = 0;
    end else if (x > 220 && x < 420 && y > 140 && y < 340) begin
      m.pr = 15; m.pg = 15; m.pb = 15;
    end else begin
      m.pr = 1; m.pg = 3; m.pb = 7;
    end
    return m;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input exp_t a);
    chk({tag, "_pix_stb"}, a.pix, e.pix);
    chk({tag, "_sx"}, a.sx, e.sx);
    chk({tag, "_sy"}, a.sy, e.sy);
    chk({tag, "_hsync"}, a.hs, e.hs);
    chk({tag, "_vsync"}, a.vs, e.vs);
    chk({tag, "_de"}, a.de, e.de);
    chk({tag, "_line"}, a.line, e.line);
    chk({tag, "_frame"}, a.frame, e.frame);
`ifdef VGA_480P_TEST_PATTERN_EN
    chk({tag, "_pat_r"}, a.pr, e.pr);
    chk({tag, "_pat_g"}, a.pg, e.pg);
    chk({tag, "_pat_b"}, a.pb, e.pb);
`endif
  endtask

  // One clock: update the models for the edge just taken, drive new resets, queue expectations.
  task automatic tick(input bit ra, input bit rb);
    @(posedge clk);
    if (rst_a) k_a = 0; else k_a++;
    if (rst_b) k_b = 0; else k_b++;
    #1;
    rst_a = ra;
    rst_b = rb;
    q_a.push_back(model(k_a, ra, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0));
    q_b.push_back(model(k_b, rb, 4, 8, 2, 3, 2, 6, 1, 2, 2, 1));
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      aa.pix = int'(pix_a); aa.sx = int'(sx_a); aa.sy = int'(sy_a);
      aa.hs = int'(hs_a); aa.vs = int'(vs_a); aa.de = int'(de_a);
      aa.line = int'(line_a); aa.frame = int'(frame_a);
`ifdef VGA_480P_TEST_PATTERN_EN
      aa.pr = int'(pr_a); aa.pg = int'(pg_a); aa.pb = int'(pb_a);
`else
      aa.pr = 0; aa.pg = 0; aa.pb = 0;
`endif
      cmp("a", ea, aa);
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      ab.pix = int'(pix_b); ab.sx = int'(sx_b); ab.sy = int'(sy_b);
      ab.hs = int'(hs_b); ab.vs = int'(vs_b); ab.de = int'(de_b);
      ab.line = int'(line_b); ab.frame = int'(frame_b);
`ifdef VGA_480P_TEST_PATTERN_EN
      ab.pr = int'(pr_b); ab.pg = int'(pg_b); ab.pb = int'(pb_b);
`else
      ab.pr = 0; ab.pg = 0; ab.pb = 0;
`endif
      cmp("b", eb, ab);
    end
  end

  initial begin
    int first, second, cnt;
    logic prev;
    //            k     sx   sy pix de hs line frame
    tbl[0]  = '{0,    0,   0, 0, 1, 1, 1, 1};
    tbl[1]  = '{1,    0,   0, 1, 1, 1, 1, 1};
    tbl[2]  = '{2,    1,   0, 0, 1, 1, 0, 0};
    tbl[3]  = '{1279, 639, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{1280, 640, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1311, 655, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{1312, 656, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1503, 751, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1504, 752, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{1599, 799, 0, 1, 0, 1, 0, 0};
    tbl[10] = '{1600, 0,   1, 0, 1, 1, 1, 0};
    tbl[11] = '{1602, 1,   1, 0, 1, 1, 0, 0};

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    #1;
    chk("rst_a_sx", int'(sx_a), 0);
    chk("rst_a_sy", int'(sy_a), 0);
    chk("rst_a_pix_stb", int'(pix_a), 0);
    chk("rst_a_de", int'(de_a), 0);
    chk("rst_a_hsync", int'(hs_a), 1);
    chk("rst_a_vsync", int'(vs_a), 1);
    chk("rst_a_frame", int'(frame_a), 0);
    chk("rst_b_hsync", int'(hs_b), 0);
    chk("rst_b_vsync", int'(vs_b), 0);

    tick(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      while (k_a < tbl[i].k) tick(1'b0, 1'b0);
      #1;
      chk($sformatf("tbl_k%0d_sx", tbl[i].k), int'(sx_a), tbl[i].sx);
      chk($sformatf("tbl_k%0d_sy", tbl[i].k), int'(sy_a), tbl[i].sy);
      chk($sformatf("tbl_k%0d_pix_stb", tbl[i].k), int'(pix_a), tbl[i].pix);
      chk($sformatf("tbl_k%0d_de", tbl[i].k), int'(de_a), tbl[i].de);
      chk($sformatf("tbl_k%0d_hsync", tbl[i].k), int'(hs_a), tbl[i].hs);
      chk($sformatf("tbl_k%0d_line", tbl[i].k), int'(line_a), tbl[i].line);
      chk($sformatf("tbl_k%0d_frame", tbl[i].k), int'(frame_a), tbl[i].frame);
    end

    // One-cycle reset in the middle of line 1 on the full-size instance.
    while (k_a < 2200) tick(1'b0, 1'b0);
    #1;
    chk("midrst_a_pre_sx", int'(sx_a), 300);
    chk("midrst_a_pre_sy", int'(sy_a), 1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    #1;
    chk("midrst_a_sx", int'(sx_a), 0);
    chk("midrst_a_sy", int'(sy_a), 0);
    chk("midrst_a_pix_stb", int'(pix_a), 0);
    tick(1'b0, 1'b0);
    #1;
    chk("midrst_a_first_stb", int'(pix_a), 1);
    chk("midrst_a_hold_sx", int'(sx_a), 0);
    tick(1'b0, 1'b0);
    #1;
    chk("midrst_a_next_sx", int'(sx_a), 1);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0);
      #2;
      if (pix_b) cnt++;
    end
    chk("b_stb_per_40", cnt, 10);

    // Frame-to-frame spacing on the shrunk instance: 15*11*4 clocks.
    first = -1;
    second = -1;
    prev = 1'b1;
    for (int i = 0; i < 2000 && second < 0; i++) begin
      tick(1'b0, 1'b0);
      #2;
      if (frame_b && !prev) begin
        if (first < 0) first = i;
        else second = i;
      end
      prev = frame_b;
    end
    if (second < 0) chk("b_frame_found", 0, 1);
    else chk("b_frame_period", second - first, 660);

    cnt = 0;
    while ((k_b % 660) != 260 && cnt < 700) begin
      tick(1'b0, 1'b0);
      cnt++;
    end
    #1;
    chk("midrst_b_pre_sx", int'(sx_b), 5);
    chk("midrst_b_pre_sy", int'(sy_b), 4);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    #1;
    chk("midrst_b_sx", int'(sx_b), 0);
    chk("midrst_b_sy", int'(sy_b), 0);
    for (int i = 0; i < 200; i++) tick(1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
